// File: rtl/tx_channel_mux.sv
// tx_channel_mux: registered N:1 channel multiplexer for the transmit path.
//
// Selects one of N request channels (manual select or round-robin), captures
// its W-bit word into a one-deep output register and presents it to the
// transmit FSM over a valid/ready handshake.  The source whose word was
// captured sees a one-cycle in_ack pulse in the cycle after the capture edge.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    N*W flattened channel data, channel k at [k*W +: W]
//   in_req     per-channel request
//   mode       0 = manual select, 1 = round-robin
//   sel        channel index used in manual mode
//   in_ack     one-hot capture acknowledge, one cycle
//   out_data   registered selected word
//   out_ch     channel index of out_data
//   out_valid  out_data/out_ch hold a word
//   out_ready  consumer accepts when out_valid && out_ready
//   out_parity XOR of the captured word (only with TXMUX_PARITY_EN defined)
//
// Optional feature macro: TXMUX_PARITY_EN
//
// state | meaning
// EMPTY | output register holds no word (out_valid = 0)
// FULL  | output register holds a word awaiting acceptance (out_valid = 1)

module tx_channel_mux #(
  parameter int W     = 1,
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_req,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     in_ack,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready
`ifdef TXMUX_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] last_grant;
  logic [W-1:0]     ch_data [N];

  logic             load_en;
  logic             man_hit;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   scan_sum;
  logic [SEL_W-1:0] scan_idx;
  logic             cand_hit;
  logic [SEL_W-1:0] cand;
  logic [N-1:0]     ack_onehot;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*W +: W];
  end

  assign out_valid = (state == FULL);
  assign load_en   = (state == EMPTY) || (out_valid && out_ready);

  // sel may exceed N-1 when N is not a power of two; such a select never hits.
  assign man_hit = (int'(sel) < N) && in_req[sel];

  // Scan from last_grant+1 upward with wrap.  last_grant < N and the offset
  // is at most N, so a single conditional subtraction replaces the modulo.
  always_comb begin
    rr_hit   = 1'b0;
    rr_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 1; i <= N; i++) begin
      scan_sum = {1'b0, last_grant} + (SEL_W+1)'(i);
      if (int'(scan_sum) >= N) begin
        scan_sum = scan_sum - (SEL_W+1)'(N);
      end
      scan_idx = scan_sum[SEL_W-1:0];
      if (!rr_hit && in_req[scan_idx]) begin
        rr_hit = 1'b1;
        rr_idx = scan_idx;
      end
    end
  end

  assign cand_hit   = mode ? rr_hit : man_hit;
  assign cand       = mode ? rr_idx : sel;
  assign ack_onehot = N'(1) << cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_ch     <= '0;
      in_ack     <= '0;
      last_grant <= SEL_W'(N-1);
    end else begin
      in_ack <= '0;
      if (load_en) begin
        if (cand_hit) begin
          state    <= FULL;
          out_data <= ch_data[cand];
          out_ch   <= cand;
          in_ack   <= ack_onehot;
          if (mode) begin
            last_grant <= cand;
          end
        end else begin
          state <= EMPTY;
        end
      end
    end
  end

`ifdef TXMUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (load_en && cand_hit) begin
      out_parity <= ^ch_data[cand];
    end
  end
`endif

endmodule

// File: tb/tb_tx_channel_mux.sv
module tb_tx_channel_mux;
  localparam int W  = 8;
  localparam int NA = 16;
  localparam int NB = 10;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [NA*W-1:0] a_data;
  logic [NA-1:0]   a_req;
  logic            a_mode;
  logic [SW-1:0]   a_sel;
  logic            a_rdy;
  logic [NA-1:0]   a_ack;
  logic [W-1:0]    a_odata;
  logic [SW-1:0]   a_och;
  logic            a_ovalid;

  logic [NB*W-1:0] b_data;
  logic [NB-1:0]   b_req;
  logic            b_mode;
  logic [SW-1:0]   b_sel;
  logic            b_rdy;
  logic [NB-1:0]   b_ack;
  logic [W-1:0]    b_odata;
  logic [SW-1:0]   b_och;
  logic            b_ovalid;

`ifdef TXMUX_PARITY_EN
  logic a_par, b_par;
`endif

  tx_channel_mux #(.W(W), .N(NA), .SEL_W(SW)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_req(a_req), .mode(a_mode),
    .sel(a_sel), .in_ack(a_ack), .out_data(a_odata), .out_ch(a_och),
    .out_valid(a_ovalid), .out_ready(a_rdy)
`ifdef TXMUX_PARITY_EN
    , .out_parity(a_par)
`endif
  );

  tx_channel_mux #(.W(W), .N(NB), .SEL_W(SW)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_req(b_req), .mode(b_mode),
    .sel(b_sel), .in_ack(b_ack), .out_data(b_odata), .out_ch(b_och),
    .out_valid(b_ovalid), .out_ready(b_rdy)
`ifdef TXMUX_PARITY_EN
    , .out_parity(b_par)
`endif
  );

  // Reference model: what the output register should hold after each edge.
  typedef struct {
    bit        full;
    bit [7:0]  data;
    int        ch;
    int        lg;
    bit [15:0] ack;
  } mst_t;

  function automatic mst_t mstep(mst_t s, int n, bit r, bit md, int sl,
                                 bit [15:0] req, bit [127:0] dat, bit rdy);
    mst_t o = s;
    int c = -1;
    o.ack = '0;
    if (r) begin
      o.full = 1'b0; o.data = '0; o.ch = 0; o.lg = n - 1;
      return o;
    end
    if (s.full && !rdy) return o;
    if (!md) begin
      if (sl < n && req[sl]) c = sl;
    end else begin
      for (int off = 1; off <= n; off++) begin
        int k = (s.lg + off) % n;
        if (c < 0 && req[k]) c = k;
      end
    end
    if (c < 0) begin
      o.full = 1'b0;
    end else begin
      o.full   = 1'b1;
      o.data   = dat[c*8 +: 8];
      o.ch     = c;
      o.ack[c] = 1'b1;
      if (md) o.lg = c;
    end
    return o;
  endfunction

  mst_t ma, mb;
  mst_t qa[$], qb[$];

  always @(posedge clk) begin
    ma = mstep(ma, NA, rst, a_mode, int'(a_sel), a_req, a_data, a_rdy);
    qa.push_back(ma);
    mb = mstep(mb, NB, rst, b_mode, int'(b_sel), 16'(b_req), 128'(b_data), b_rdy);
    qb.push_back(mb);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    mst_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      cmp("a_valid", 32'(a_ovalid), 32'(e.full));
      cmp("a_data",  32'(a_odata),  32'(e.data));
      cmp("a_ch",    32'(a_och),    32'(e.ch));
      cmp("a_ack",   32'(a_ack),    32'(e.ack));
`ifdef TXMUX_PARITY_EN
      cmp("a_parity", 32'(a_par), 32'(^e.data));
`endif
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      cmp("b_valid", 32'(b_ovalid), 32'(e.full));
      cmp("b_data",  32'(b_odata),  32'(e.data));
      cmp("b_ch",    32'(b_och),    32'(e.ch));
      cmp("b_ack",   32'(b_ack),    32'(e.ack[NB-1:0]));
`ifdef TXMUX_PARITY_EN
      cmp("b_parity", 32'(b_par), 32'(^e.data));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_req = '0; a_mode = 1'b0; a_sel = '0; a_rdy = 1'b0;
    b_data = '0; b_req = '1; b_mode = 1'b0; b_sel = 4'd12; b_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset while a word is held
    a_sel = 4'd5; a_req = 16'h0020; a_data[5*W +: W] = 8'hA5;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; a_req = '0; tick();

    // round-robin wrap between channels 0 and 15
    rst = 1'b1; tick(); rst = 1'b0;
    a_mode = 1'b1; a_req = 16'h8001; a_rdy = 1'b1;
    repeat (8) tick();

    // backpressure: held word survives input changes
    a_mode = 1'b0; a_req = '0; rst = 1'b1; tick(); rst = 1'b0;
    a_sel = 4'd3; a_data[3*W +: W] = 8'h3C; a_req = 16'h0008; a_rdy = 1'b0;
    tick(); a_req = '0;
    repeat (4) tick();
    a_data[3*W +: W] = 8'h11; a_req = 16'h0008;
    tick(); tick();
    a_rdy = 1'b1; tick(); a_req = '0; tick(); tick();

    // mode change while full
    rst = 1'b1; tick(); rst = 1'b0;
    a_mode = 1'b0; a_sel = 4'd2; a_req = 16'h0014; a_data[2*W +: W] = 8'h77; a_rdy = 1'b0;
    tick(); a_mode = 1'b1; tick(); tick();
    a_rdy = 1'b1; tick(); a_req = '0; tick(); tick();

    // parity words
    a_mode = 1'b0; a_sel = 4'd0; a_data[0 +: W] = 8'h07; a_req = 16'h0001;
    tick();
    a_sel = 4'd5; a_req = 16'h0020; a_data[5*W +: W] = 8'hA5;
    tick(); a_req = '0; tick();

    // randomized traffic on both instances
    repeat (600) begin
      rst    = ($urandom_range(0, 59) == 0);
      a_data = 128'({$urandom(), $urandom(), $urandom(), $urandom()});
      a_req  = 16'($urandom()) & 16'($urandom());
      a_mode = ($urandom_range(0, 2) != 0);
      a_sel  = 4'($urandom_range(0, 15));
      a_rdy  = ($urandom_range(0, 3) != 0);
      b_data = 80'({$urandom(), $urandom(), $urandom()});
      b_req  = 10'($urandom());
      b_mode = 1'($urandom_range(0, 1));
      b_sel  = 4'($urandom_range(0, 15));
      b_rdy  = 1'($urandom_range(0, 1));
      tick();
    end

    rst = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_channel_mux.md
Name: tx_channel_mux

Overview:
- Registered N:1 channel multiplexer for the transmit path.
- Generalises the fixed 16:1, 1-bit select mux to N channels of W bits each.
- Adds a round-robin arbitration mode, a one-deep output register and a valid/ready handshake toward the transmit FSM.
- Sits between the per-channel transmit sources and the transmit FSM. Each source sees a one-cycle ack when its word is taken.

Parameters:
W, 1, data width per channel in bits (>=1)
N, 16, number of channels (2..256)
SEL_W, 4, select/channel-index width; must equal ceil(log2(N))

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  N*W  flattened channel data; channel k occupies bits [k*W +: W]
in_req  input  N  per-channel request; channel k has a word ready
mode  input  1  0 = manual select, 1 = round-robin
sel  input  SEL_W  channel index used in manual mode
in_ack  output  N  one-hot, one-cycle pulse: the marked channel's word was captured this cycle
out_data  output  W  registered selected word
out_ch  output  SEL_W  index of the channel that out_data came from
out_valid  output  1  out_data/out_ch hold a word
out_ready  input  1  consumer accepts the word on a cycle where out_valid && out_ready

Behaviour:
- Reset values:
  - out_data = 0, out_ch = 0, out_valid = 0, in_ack = 0.
  - Round-robin pointer last_grant = N-1, so the first search starts at channel 0.
- Reset overrides everything on the same edge, including a word held mid-handshake; that word is discarded with no ack or replay.
- FSM states:
  - EMPTY (out_valid = 0).
  - FULL (out_valid = 1).
- load_en = (state == EMPTY) || (out_valid && out_ready). This gives full-throughput back-to-back transfers.
- Candidate selection (combinational, evaluated every cycle):
  - Manual mode: the candidate is sel, valid only if sel < N and in_req[sel] = 1.
  - Round-robin mode: the candidate is the first k with in_req[k] = 1, scanning (last_grant+1) mod N upward with wrap-around.
  - No request means no candidate.
- On an edge with load_en and a candidate c:
  - out_data <= in_data[c*W +: W], out_ch <= c, out_valid <= 1, state FULL.
  - in_ack <= one-hot(c) for exactly that cycle.
  - In round-robin mode, last_grant <= c.
- On an edge with load_en and no candidate: out_valid <= 0, state EMPTY, in_ack <= 0.
- On an edge without load_en (FULL, not accepted):
  - out_data and out_ch are held stable, in_ack <= 0.
  - Input changes have no effect.
- Latency: a request sampled at edge t appears on out_data with out_valid = 1 after edge t. The in_ack pulse is visible in the same cycle.
- Sources must drop or advance in_req the cycle after seeing in_ack; otherwise the same word is taken again.
- Boundary conditions:
  - Manual sel >= N (N not a power of 2) never captures.
  - A mode change while FULL does not disturb the held word and takes effect at the next load_en.
  - last_grant is not updated in manual mode.
  - Single requester in round-robin mode: that channel is granted every load_en.
  - Simultaneous accept and new request: the old word is retired and the new word is loaded on the same edge. No bubble.

Optional Feature:
- Macro: TXMUX_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit) = XOR of all bits of the captured word.
  - Registered on the same edge as out_data, held with it, reset to 0.
- When undefined: the port and logic are absent and the interface is exactly as listed above.

Test Plan:
1. Reset while FULL:
   - Stimulus: W=8, N=16, manual mode, sel=5, in_req[5]=1, in_data ch5=0xA5, out_ready=0; assert rst for one cycle.
   - Before rst: out_valid=1, out_data=0xA5, out_ch=5, in_ack=0x0020 for one cycle.
   - After rst: out_valid=0, out_data=0.
2. Round-robin wrap:
   - Stimulus: in_req=0x8001 held, out_ready=1, mode=1, starting from reset.
   - out_ch sequence: 0, 15, 0, 15…; in_ack alternates 0x0001 / 0x8000; out_valid stays 1 every cycle.
3. Backpressure:
   - Stimulus: out_ready=0 for 4 cycles with ch3=0x3C captured, then change in_data ch3 to 0x11.
   - out_data stays 0x3C and no further in_ack occurs until out_ready=1.
   - The next capture yields 0x11.
4. Non-power-of-2 N:
   - Stimulus: N=10, SEL_W=4, manual mode, sel=12, all in_req=1.
   - out_valid stays 0 and in_ack stays 0.
5. Mode change while FULL:
   - Stimulus: mode 0→1 while FULL with ch2=0x77 held; in_req=0x0014.
   - Held word 0x77 is unchanged.
   - After accept, round-robin starts from last_grant = its reset value N-1, so channel 2 is granted next (out_ch=2), not channel 4.
6. Parity (with TXMUX_PARITY_EN defined):
   - Capture 0xA5 → out_parity=0; capture 0x07 → out_parity=1.
